// File: rtl/plcp_header_rx_pkg.sv
// ----------------------------------------------------------------------------
// plcp_header_rx_pkg
//  Shared constants and types for the 802.11b long-preamble PLCP header
//  receiver: header/CRC bit counts, CRC-16 (CCITT) polynomial and preset,
//  the four legal SIGNAL rate codes and the capture FSM state type.
// ----------------------------------------------------------------------------
package plcp_header_rx_pkg;

  localparam int unsigned PLCP_HDR_BITS = 32;
  localparam int unsigned PLCP_CRC_BITS = 16;

  // 1 + x^5 + x^12 + x^16, x^16 term implicit
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // SIGNAL field: data rate in units of 100 kbit/s
  localparam logic [7:0] SIG_RATE_1M  = 8'h0A;
  localparam logic [7:0] SIG_RATE_2M  = 8'h14;
  localparam logic [7:0] SIG_RATE_5M5 = 8'h37;
  localparam logic [7:0] SIG_RATE_11M = 8'h6E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } hdr_state_t;

  function automatic logic sig_legal(input logic [7:0] sig);
    return (sig == SIG_RATE_1M)  || (sig == SIG_RATE_2M) ||
           (sig == SIG_RATE_5M5) || (sig == SIG_RATE_11M);
  endfunction

endpackage

// File: rtl/plcp_header_rx.sv
// ----------------------------------------------------------------------------
// plcp_header_rx
//  Receive-side PLCP header parser/checker (802.11b, 1 Mbps DSSS). Captures
//  the 48 descrambled header bits following the SFD, recomputes CRC-16 over
//  SIGNAL/SERVICE/LENGTH and compares it with the transmitted CRC field.
//
// Ports
//  clk        clock
//  rst        asynchronous active-high reset
//  sfd_start  1-cycle pulse, the next valid bit is header bit 0
//  bit_in     descrambled serial bit
//  bit_valid  bit_in qualifier
//  busy       header capture in progress (HDR/CRC states)
//  signal_q   SIGNAL field of the last completed header
//  service_q  SERVICE field of the last completed header
//  length_q   LENGTH field of the last completed header (us)
//  hdr_done   1-cycle verdict strobe
//  hdr_ok     CRC good and SIGNAL acceptable; held until next sfd_start
//  crc_err    CRC mismatch; held until next sfd_start
//  sig_err    illegal SIGNAL code; held until next sfd_start
// ----------------------------------------------------------------------------
module plcp_header_rx
  import plcp_header_rx_pkg::*;
#(
  parameter bit CHECK_SIGNAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sfd_start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        busy,
  output logic [7:0]  signal_q,
  output logic [7:0]  service_q,
  output logic [15:0] length_q,
  output logic        hdr_done,
  output logic        hdr_ok,
  output logic        crc_err,
  output logic        sig_err
);

  localparam logic [5:0] HDR_LAST = 6'(PLCP_HDR_BITS - 1);
  localparam logic [5:0] CRC_LAST = 6'(PLCP_CRC_BITS - 1);

  hdr_state_t  state_reg;
  hdr_state_t  state_next;
  logic [5:0]  cnt_reg;
  logic [15:0] lfsr_reg;
  logic [31:0] hdr_sr;
  logic [15:0] crc_sr;

  // A start pulse is honoured in IDLE and as an abort while busy. The DONE
  // cycle always completes so that a verdict strobe is never cut short.
  logic start;
  logic hdr_bit;
  logic crc_bit;
  logic hdr_last;
  logic crc_last;

  assign start    = sfd_start && (state_reg != ST_DONE);
  assign hdr_bit  = !start && (state_reg == ST_HDR) && bit_valid;
  assign crc_bit  = !start && (state_reg == ST_CRC) && bit_valid;
  assign hdr_last = hdr_bit && (cnt_reg == HDR_LAST);
  assign crc_last = crc_bit && (cnt_reg == CRC_LAST);

  // Serial CRC step for the incoming header bit
  logic        lfsr_fb;
  logic [15:0] lfsr_step;

  assign lfsr_fb   = lfsr_reg[15] ^ bit_in;
  assign lfsr_step = {lfsr_reg[14:0], 1'b0} ^ (lfsr_fb ? CRC16_POLY : 16'h0000);

  // Verdict is evaluated on the edge that takes the last CRC bit, so it is
  // already registered and stable while hdr_done is high. The received CRC
  // field is the ones-complement of the transmitter's register.
  logic [15:0] crc_word;
  logic        crc_bad;
  logic        sig_bad;

  assign crc_word = {crc_sr[14:0], bit_in};
  assign crc_bad  = (crc_word != ~lfsr_reg);
  assign sig_bad  = CHECK_SIGNAL && !sig_legal(hdr_sr[7:0]);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sfd_start) state_next = ST_HDR;
      end
      ST_HDR: begin
        if (sfd_start)     state_next = ST_HDR;
        else if (hdr_last) state_next = ST_CRC;
      end
      ST_CRC: begin
        if (sfd_start)     state_next = ST_HDR;
        else if (crc_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg == ST_HDR) || (state_reg == ST_CRC);
  assign hdr_done = (state_reg == ST_DONE);

  // --------------------------------------------------------------------------
  // Counter, shift registers and CRC LFSR
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      lfsr_reg <= CRC16_INIT;
      hdr_sr   <= '0;
      crc_sr   <= '0;
    end else if (start) begin
      cnt_reg  <= '0;
      lfsr_reg <= CRC16_INIT;
    end else if (hdr_bit) begin
      hdr_sr   <= {bit_in, hdr_sr[31:1]};
      lfsr_reg <= lfsr_step;
      cnt_reg  <= hdr_last ? 6'd0 : cnt_reg + 6'd1;
    end else if (crc_bit) begin
      crc_sr   <= crc_word;
      cnt_reg  <= crc_last ? 6'd0 : cnt_reg + 6'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Reported fields and verdict flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signal_q  <= '0;
      service_q <= '0;
      length_q  <= '0;
      hdr_ok    <= 1'b0;
      crc_err   <= 1'b0;
      sig_err   <= 1'b0;
    end else if (start) begin
      hdr_ok    <= 1'b0;
      crc_err   <= 1'b0;
      sig_err   <= 1'b0;
    end else if (crc_last) begin
      signal_q  <= hdr_sr[7:0];
      service_q <= hdr_sr[15:8];
      length_q  <= hdr_sr[31:16];
      crc_err   <= crc_bad;
      sig_err   <= sig_bad;
      hdr_ok    <= !crc_bad && !sig_bad;
    end
  end

endmodule

// File: tb/tb_plcp_header_rx.sv
module tb_plcp_header_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sfd_start;
  logic        bit_in;
  logic        bit_valid;
  logic        busy;
  logic [7:0]  signal_q;
  logic [7:0]  service_q;
  logic [15:0] length_q;
  logic        hdr_done;
  logic        hdr_ok;
  logic        crc_err;
  logic        sig_err;

  // Second instance with SIGNAL checking disabled, sharing the stimulus
  logic        n_busy;
  logic [7:0]  n_signal_q;
  logic [7:0]  n_service_q;
  logic [15:0] n_length_q;
  logic        n_hdr_done;
  logic        n_hdr_ok;
  logic        n_crc_err;
  logic        n_sig_err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int busy_low = 0;

  always #5 clk = ~clk;

  plcp_header_rx #(.CHECK_SIGNAL(1'b1)) dut (
    .clk(clk), .rst(rst), .sfd_start(sfd_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy), .signal_q(signal_q),
    .service_q(service_q), .length_q(length_q), .hdr_done(hdr_done),
    .hdr_ok(hdr_ok), .crc_err(crc_err), .sig_err(sig_err)
  );

  plcp_header_rx #(.CHECK_SIGNAL(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .sfd_start(sfd_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(n_busy), .signal_q(n_signal_q),
    .service_q(n_service_q), .length_q(n_length_q), .hdr_done(n_hdr_done),
    .hdr_ok(n_hdr_ok), .crc_err(n_crc_err), .sig_err(n_sig_err)
  );

  always @(posedge clk) if (hdr_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitted CRC field via polynomial long division: the first 32 bits
  // form the message (first bit = highest degree), the all-ones preset is
  // equivalent to inverting the first 16 message bits, and the field sent
  // is the complemented remainder.
  function automatic logic [15:0] tx_crc(input logic [31:0] hdr);
    logic [47:0] dividend;
    logic [31:0] msg;
    for (int i = 0; i < 32; i++) msg[31 - i] = hdr[i];
    msg[31:16] = ~msg[31:16];
    dividend = {msg, 16'h0000};
    for (int d = 47; d >= 16; d--)
      if (dividend[d]) dividend = dividend ^ (48'h11021 << (d - 16));
    return ~dividend[15:0];
  endfunction

  // 48-bit on-air frame, element i is the i-th transmitted bit
  function automatic logic [47:0] make_frame(input logic [7:0] sg, input logic [7:0] sv,
                                             input logic [15:0] ln, input logic [15:0] flip);
    logic [31:0] hdr;
    logic [15:0] c;
    logic [47:0] f;
    hdr = {ln, sv, sg};
    c   = tx_crc(hdr) ^ flip;
    f[31:0] = hdr;
    for (int k = 0; k < 16; k++) f[32 + k] = c[15 - k];
    return f;
  endfunction

  function automatic bit legal(input logic [7:0] s);
    return s inside {8'h0A, 8'h14, 8'h37, 8'h6E};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sfd();
    sfd_start = 1'b1;
    tick();
    sfd_start = 1'b0;
  endtask

  // Sends bits 0..nbits-1 of frame with 'gap' idle cycles before each bit.
  // Counts cycles where busy is low while the capture should still be open.
  task automatic send_bits(input logic [47:0] frame, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (!busy) busy_low++;
        tick();
      end
      if (!busy) busy_low++;
      bit_in    = frame[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  task automatic chk_verdict(input string tag, input logic [7:0] sg, input logic [7:0] sv,
                             input logic [15:0] ln, input bit c_err);
    bit s_err;
    s_err = !legal(sg);
    chk({tag, ".done"},   32'(hdr_done),  32'd1);
    chk({tag, ".signal"}, 32'(signal_q),  32'(sg));
    chk({tag, ".service"},32'(service_q), 32'(sv));
    chk({tag, ".length"}, 32'(length_q),  32'(ln));
    chk({tag, ".crc_err"},32'(crc_err),   32'(c_err));
    chk({tag, ".sig_err"},32'(sig_err),   32'(s_err));
    chk({tag, ".hdr_ok"}, 32'(hdr_ok),    32'(!c_err && !s_err));
    chk({tag, ".nochk_ok"}, 32'(n_hdr_ok), 32'(!c_err));
  endtask

  initial begin
    logic [47:0] fr;
    logic [7:0]  sg;
    logic [7:0]  sv;
    logic [15:0] ln;
    logic [15:0] flip;
    int          gap;
    int          d0;
    logic [7:0]  legal_tab [4];

    legal_tab[0] = 8'h0A; legal_tab[1] = 8'h14;
    legal_tab[2] = 8'h37; legal_tab[3] = 8'h6E;

    rst = 1'b1; sfd_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst.busy",    32'(busy),     32'd0);
    chk("rst.done",    32'(hdr_done), 32'd0);
    chk("rst.ok",      32'(hdr_ok),   32'd0);
    chk("rst.fields",  {signal_q, service_q, length_q}, 32'd0);
    chk("rst.errs",    32'({crc_err, sig_err}), 32'd0);
    rst = 1'b0;
    tick();
    // Bits with no preceding SFD are ignored
    send_bits(48'hFFFF_FFFF_FFFF, 8, 0);
    chk("idle.busy", 32'(busy), 32'd0);

    // Test 1: nominal header, gapless; verdict appears on the 48th bit edge
    fr = make_frame(8'h0A, 8'h00, 16'h0100, 16'h0000);
    pulse_sfd();
    chk("t1.busy_after_sfd", 32'(busy), 32'd1);
    send_bits(fr, 47, 0);
    chk("t1.no_early_done", 32'(hdr_done), 32'd0);
    send_bits(fr >> 47, 1, 0);
    chk_verdict("t1", 8'h0A, 8'h00, 16'h0100, 1'b0);
    chk("t1.busy_in_done", 32'(busy), 32'd0);
    tick();
    chk("t1.done_pulse", 32'(hdr_done), 32'd0);
    chk("t1.ok_held",    32'(hdr_ok),   32'd1);
    $display("txn t1: sig=0A len=0100 ok=%0b", hdr_ok);

    // Test 2: CRC bit 7 corrupted
    fr = make_frame(8'h0A, 8'h00, 16'h0100, 16'h0080);
    pulse_sfd();
    chk("t2.ok_cleared", 32'(hdr_ok), 32'd0);
    send_bits(fr, 48, 0);
    chk_verdict("t2", 8'h0A, 8'h00, 16'h0100, 1'b1);
    tick();
    chk("t2.crc_err_held", 32'(crc_err), 32'd1);
    $display("txn t2: crc bit7 flipped crc_err=%0b", crc_err);

    // Test 3: illegal SIGNAL with good CRC
    fr = make_frame(8'h0B, 8'h00, 16'h0100, 16'h0000);
    pulse_sfd();
    chk("t3.crc_err_cleared", 32'(crc_err), 32'd0);
    send_bits(fr, 48, 0);
    chk_verdict("t3", 8'h0B, 8'h00, 16'h0100, 1'b0);
    tick();
    $display("txn t3: sig=0B sig_err=%0b nochk_ok=%0b", sig_err, n_hdr_ok);

    // Test 4: chip-rate pacing, one valid bit every 11th cycle
    fr = make_frame(8'h0A, 8'h00, 16'h0100, 16'h0000);
    busy_low = 0;
    pulse_sfd();
    send_bits(fr, 48, 10);
    chk_verdict("t4", 8'h0A, 8'h00, 16'h0100, 1'b0);
    chk("t4.busy_throughout", 32'(busy_low), 32'd0);
    tick();
    $display("txn t4: paced ok=%0b", hdr_ok);

    // Test 5: abort after 20 bits, then a full header; one strobe only
    d0 = done_cnt;
    fr = make_frame(8'h37, 8'h04, 16'h1234, 16'h0000);
    pulse_sfd();
    send_bits(make_frame(8'h6E, 8'hFF, 16'hBEEF, 16'h0000), 20, 0);
    pulse_sfd();
    send_bits(fr, 48, 0);
    chk_verdict("t5", 8'h37, 8'h04, 16'h1234, 1'b0);
    tick();
    chk("t5.one_done", 32'(done_cnt - d0), 32'd1);
    $display("txn t5: abort+restart dones=%0d", done_cnt - d0);

    // Test 6: asynchronous reset after 40 bits, then a new header
    d0 = done_cnt;
    pulse_sfd();
    send_bits(make_frame(8'h14, 8'h00, 16'h00FF, 16'h0000), 40, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_busy",   32'(busy),   32'd0);
    chk("t6.rst_fields", {signal_q, service_q, length_q}, 32'd0);
    chk("t6.rst_flags",  32'({hdr_done, hdr_ok, crc_err, sig_err}), 32'd0);
    tick();
    rst = 1'b0;
    send_bits(48'hFFFF_FFFF_FFFF, 8, 0);
    chk("t6.no_done", 32'(done_cnt - d0), 32'd0);
    fr = make_frame(8'h14, 8'h5A, 16'h0ABC, 16'h0000);
    pulse_sfd();
    send_bits(fr, 48, 1);
    chk_verdict("t6", 8'h14, 8'h5A, 16'h0ABC, 1'b0);
    tick();
    $display("txn t6: post-reset ok=%0b", hdr_ok);

    // Randomized headers against the reference model
    for (int n = 0; n < 24; n++) begin
      sg   = ($urandom_range(0, 3) != 0) ? legal_tab[$urandom_range(0, 3)] : 8'($urandom);
      sv   = 8'($urandom);
      ln   = 16'($urandom);
      flip = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      gap  = $urandom_range(0, 3);
      fr   = make_frame(sg, sv, ln, flip);
      pulse_sfd();
      send_bits(fr, 48, gap);
      chk_verdict("rnd", sg, sv, ln, flip != 16'h0000);
      $display("txn rnd%0d: sig=%02h svc=%02h len=%04h flip=%04h gap=%0d ok=%0b",
               n, sg, sv, ln, flip, gap, hdr_ok);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
